// File: rtl/chr_text_writer_pkg.sv
// Shared definitions for the character-map text writer: control codes, glyph range,
// FSM encoding and the cell payload layout.
package chr_text_writer_pkg;

  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  localparam logic [7:0] GLYPH_BASE = 8'h20;
  localparam logic [7:0] GLYPH_LAST = 8'h5F;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
  localparam logic [STATE_W-1:0] ST_CLEAR = 1'b1;

  // One character-map cell as written to the BG map.
  typedef struct packed {
    logic [1:0] palette;
    logic [5:0] glyph;
  } chr_cell_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= GLYPH_BASE) && (b <= GLYPH_LAST);
  endfunction

endpackage

// File: rtl/chr_text_writer_if.sv
// Byte-stream handshake feeding the text writer.
interface chr_text_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/chr_text_writer.sv
// Turns an ASCII/control byte stream into character-map write cycles, keeping a
// text cursor and running a full-map clear on form feed.
module chr_text_writer
  import chr_text_writer_pkg::*;
#(
  parameter int unsigned CHR_SIZE_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  chr_text_writer_if.slave         bus,
  input  logic [1:0]               palette_sel,
  input  logic                     cursor_set,
  input  logic [CHR_SIZE_BITS-1:0] cursor_col,
  input  logic [CHR_SIZE_BITS-1:0] cursor_row,
  output logic signed [31:0]       chr_address,
  output logic signed [7:0]        chr_din,
  output logic                     chr_we,
  output logic                     busy,
  output logic [CHR_SIZE_BITS-1:0] cur_col,
  output logic [CHR_SIZE_BITS-1:0] cur_row
);

  localparam int unsigned CW = CHR_SIZE_BITS;
  localparam int unsigned AW = 2 * CHR_SIZE_BITS;

  logic [STATE_W-1:0] state, state_nxt;
  logic [AW-1:0]      clr_cnt, clr_nxt;
  logic [CW-1:0]      col_nxt, row_nxt;
  logic               we_nxt, busy_nxt;
  logic [31:0]        addr_nxt;
  chr_cell_t          cell_nxt;

  // cursor_set takes priority over a byte offered in the same cycle
  assign bus.in_ready = (state == ST_IDLE) && !cursor_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      clr_cnt     <= '0;
      cur_col     <= '0;
      cur_row     <= '0;
      chr_we      <= 1'b0;
      chr_address <= '0;
      chr_din     <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_nxt;
      cur_col     <= col_nxt;
      cur_row     <= row_nxt;
      chr_we      <= we_nxt;
      chr_address <= addr_nxt;
      chr_din     <= 8'(cell_nxt);
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    col_nxt   = cur_col;
    row_nxt   = cur_row;
    we_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    addr_nxt  = chr_address;
    cell_nxt  = chr_cell_t'(chr_din);

    case (state)
      ST_IDLE: begin
        if (cursor_set) begin
          col_nxt = cursor_col;
          row_nxt = cursor_row;
        end else if (bus.in_valid) begin
          if (is_printable(bus.in_data)) begin
            we_nxt   = 1'b1;
            addr_nxt = 32'({cur_row, cur_col});
            cell_nxt = '{palette: palette_sel, glyph: 6'(bus.in_data - GLYPH_BASE)};
            col_nxt  = cur_col + CW'(1);
            if (cur_col == '1) row_nxt = cur_row + CW'(1);
          end else begin
            case (bus.in_data)
              CC_LF: begin
                col_nxt = '0;
                row_nxt = cur_row + CW'(1);
              end
              CC_CR: col_nxt = '0;
              CC_BS: if (cur_col != '0) col_nxt = cur_col - CW'(1);
              // Cell 0 is issued on the accepting edge so the clear starts at once
              CC_FF: begin
                state_nxt = ST_CLEAR;
                busy_nxt  = 1'b1;
                col_nxt   = '0;
                row_nxt   = '0;
                we_nxt    = 1'b1;
                addr_nxt  = '0;
                cell_nxt  = '{palette: palette_sel, glyph: 6'd0};
                clr_nxt   = AW'(1);
              end
              default: ;
            endcase
          end
        end
      end

      // clr_cnt wraps to zero once the last cell has been issued
      ST_CLEAR: begin
        if (clr_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          busy_nxt = 1'b1;
          we_nxt   = 1'b1;
          addr_nxt = 32'(clr_cnt);
          cell_nxt = '{palette: palette_sel, glyph: 6'd0};
          clr_nxt  = clr_cnt + AW'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_chr_text_writer.sv
// Bench for chr_text_writer: directed scenarios plus random byte traffic, all checked
// cycle by cycle against a cursor/map reference model.
module tb_chr_text_writer;

  localparam int N     = 64;
  localparam int CELLS = N * N;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  palette_sel;
  logic        cursor_set;
  logic [5:0]  cursor_col, cursor_row;
  logic signed [31:0] chr_address;
  logic signed [7:0]  chr_din;
  logic        chr_we, busy;
  logic [5:0]  cur_col, cur_row;

  chr_text_writer_if bus();

  chr_text_writer #(.CHR_SIZE_BITS(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .palette_sel (palette_sel),
    .cursor_set  (cursor_set),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .chr_address (chr_address),
    .chr_din     (chr_din),
    .chr_we      (chr_we),
    .busy        (busy),
    .cur_col     (cur_col),
    .cur_row     (cur_row)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_writes = 0;

  // Reference model: cursor, clear progress and expected write-port contents
  int m_col, m_row, m_next, e_addr, e_din;
  bit m_busy, e_we;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("chr_we", 32'(chr_we), 32'(e_we));
    check_eq("chr_address", chr_address, e_addr);
    check_eq("chr_din", {24'd0, chr_din}, e_din);
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("cur_col", {26'd0, cur_col}, m_col);
    check_eq("cur_row", {26'd0, cur_row}, m_row);
  endtask

  // Called at posedge+1; applies inputs for one cycle and checks both sides of the edge
  task automatic cycle(input bit v, input int d, input bit cs, input int cc, input int cr,
                       input int pal);
    bit acc;
    bus.in_valid = v;
    bus.in_data  = 8'(d);
    cursor_set   = cs;
    cursor_col   = 6'(cc);
    cursor_row   = 6'(cr);
    palette_sel  = 2'(pal);
    #1;
    acc = v && !m_busy && !cs;
    check_eq("in_ready", 32'(bus.in_ready), 32'(!m_busy && !cs));
    @(posedge clk);
    e_we = 1'b0;
    if (m_busy) begin
      if (m_next < CELLS) begin
        e_we = 1'b1; e_addr = m_next; e_din = pal * 64; m_next++;
      end else begin
        m_busy = 1'b0;
      end
    end else if (cs) begin
      m_col = cc; m_row = cr;
    end else if (acc) begin
      if (d >= 'h20 && d <= 'h5F) begin
        e_we = 1'b1; e_addr = m_row * N + m_col; e_din = pal * 64 + (d - 'h20);
        m_col++;
        if (m_col == N) begin m_col = 0; m_row = (m_row + 1) % N; end
      end else if (d == 'h0A) begin
        m_col = 0; m_row = (m_row + 1) % N;
      end else if (d == 'h0D) begin
        m_col = 0;
      end else if (d == 'h08) begin
        if (m_col > 0) m_col--;
      end else if (d == 'h0C) begin
        m_busy = 1'b1; e_we = 1'b1; e_addr = 0; e_din = pal * 64; m_next = 1;
        m_col = 0; m_row = 0;
      end
    end
    #1;
    check_outputs();
    if (chr_we) n_writes++;
  endtask

  task automatic reset_pulse();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    cursor_set   = 1'b0;
    cursor_col   = '0;
    cursor_row   = '0;
    palette_sel  = '0;
    reset = 1'b1;
    #2;
    m_col = 0; m_row = 0; m_busy = 1'b0; m_next = 0;
    e_we = 1'b0; e_addr = 0; e_din = 0;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r, sel, d;
    bit v, cs;

    reset_pulse();

    // "AB" with palette 2
    cycle(1, 'h41, 0, 0, 0, 2);
    cycle(1, 'h42, 0, 0, 0, 2);
    check_eq("ab_col", {26'd0, cur_col}, 2);
    cycle(0, 0, 0, 0, 0, 2);

    // Cursor load and end-of-line / end-of-map wrap
    cycle(0, 0, 1, 63, 5, 0);
    cycle(1, 'h58, 0, 0, 0, 0);
    check_eq("x_addr", chr_address, 383);
    cycle(0, 0, 1, 63, 63, 0);
    cycle(1, 'h58, 0, 0, 0, 0);
    check_eq("wrap_addr", chr_address, 4095);

    // Q, LF, CR, BS from (3,0)
    cycle(0, 0, 1, 3, 0, 0);
    cycle(1, 'h51, 0, 0, 0, 0);
    cycle(1, 'h0A, 0, 0, 0, 0);
    cycle(1, 'h0D, 0, 0, 0, 0);
    cycle(1, 'h08, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Full clear with in_valid held high throughout
    n_writes = 0;
    cycle(1, 'h0C, 0, 0, 0, 1);
    repeat (CELLS) cycle(1, 'h41, 0, 0, 0, 1);
    check_eq("clear_writes", n_writes, CELLS);
    cycle(1, 'h41, 0, 0, 0, 1);
    check_eq("post_clear_addr", chr_address, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset during a clear
    cycle(1, 'h0C, 0, 0, 0, 3);
    repeat (1000) cycle(0, 0, 0, 0, 0, 3);
    check_eq("mid_clear_addr", chr_address, 1000);
    reset_pulse();
    cycle(1, 'h41, 0, 0, 0, 0);
    check_eq("post_reset_addr", chr_address, 0);

    // cursor_set beats a simultaneous byte; 0x7F is swallowed
    cycle(1, 'h41, 1, 10, 7, 0);
    cycle(1, 'h41, 0, 0, 0, 0);
    check_eq("deferred_addr", chr_address, 7 * 64 + 10);
    cycle(1, 'h7F, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Random traffic
    repeat (6000) begin
      r   = $urandom_range(0, 99);
      v   = (r < 70);
      sel = $urandom_range(0, 19);
      case (sel)
        0: d = 'h0A;
        1: d = 'h0D;
        2: d = 'h08;
        3: d = ($urandom_range(0, 199) == 0) ? 'h0C : 'h20 + $urandom_range(0, 63);
        4: begin
          d = $urandom_range(0, 255);
          if (d == 'h0C) d = 'h0B;
        end
        default: d = 'h20 + $urandom_range(0, 63);
      endcase
      cs = ($urandom_range(0, 19) == 0);
      cycle(v, d, cs, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chr_text_writer.md
# chr_text_writer

Terminal-style writer for the background character map: accepts a byte stream of ASCII text and control codes on the system clock and turns it into write cycles on the character-map write port (address/data/write-enable) that the BG renderer reads from. Keeps a text cursor, handles line feed, carriage return, backspace and clear-screen, and applies a palette select to every written cell.

## Interface
- CHR_SIZE_BITS, 6, log2 of map width and height in cells; map is 2^CHR_SIZE_BITS × 2^CHR_SIZE_BITS.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted on a rising edge where in_valid && in_ready.
- palette_sel  in  2  palette index placed in chr_din[7:6] of every write.
- cursor_set  in  1  one-cycle strobe that loads the cursor.
- cursor_col  in  CHR_SIZE_BITS  column loaded by cursor_set.
- cursor_row  in  CHR_SIZE_BITS  row loaded by cursor_set.
- chr_address  out  32 signed  map write address = row·2^CHR_SIZE_BITS + col; upper bits are 0.
- chr_din  out  8 signed  cell value {palette_sel, glyph[5:0]}.
- chr_we  out  1  write strobe, one cell per high cycle.
- busy  out  1  clear in progress.
- cur_col, cur_row  out  CHR_SIZE_BITS each  current cursor.

## Operation
- States: IDLE, CLEAR.
- in_ready = (state == IDLE) && !cursor_set. When cursor_set and in_valid arrive together, cursor_set wins and the byte waits.
- cursor_set applies only in IDLE and is ignored in CLEAR.
- Accepted byte b, processed in IDLE:
  - 0x20–0x5F, printable: write glyph b−0x20 at the cursor, then col+1. When col = max, col wraps to 0 and row+1. When row = max, row wraps to 0. No scrolling.
  - 0x0A (LF): col=0, row+1 with wrap. No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): col−1, saturating at 0. No write, no erase.
  - 0x0C (FF): enter CLEAR. Every cell 0..2^(2·CHR_SIZE_BITS)−1 is written with {palette_sel, 6'd0} (glyph 0 = space), in ascending address order. Cursor is set to (0,0). Return to IDLE after the last cell.
  - Any other byte is consumed with no effect.
- palette_sel is sampled:
  - at acceptance for a printable byte;
  - each cycle during CLEAR.
- Reset, asynchronous, including during CLEAR, sets:
  - state=IDLE;
  - cursor (0,0);
  - chr_we=0, chr_address=0, chr_din=0, busy=0.
  - in_ready goes high in the first cycle after reset deasserts, subject to cursor_set.
  - A clear interrupted by reset is abandoned and not resumed.

## Timing
- All outputs are registered.
- Printable byte accepted at edge N:
  - chr_we=1 during cycle N+1, with address = cursor before advance;
  - cur_col/cur_row show the advanced cursor from edge N;
  - throughput is one byte per cycle. Back-to-back printables produce back-to-back writes.
- chr_we=0 in every cycle that does not carry a write. chr_address/chr_din hold their last values when chr_we=0.
- FF accepted at edge N:
  - busy=1 and in_ready=0 for cycles N+1 .. N+2^(2·CHR_SIZE_BITS);
  - chr_we=1 in each of those cycles, address 0,1,…,max;
  - cursor becomes (0,0) at edge N;
  - in_ready returns high in the following cycle.
- A write pending from a printable accepted just before FF completes in cycle N, before the clear starts.
- cursor_set at edge N: cur_col/cur_row show the new values from N+1. The next printable uses them.

## Structure
- Shared package holds:
  - control-code constants CC_LF=0x0A, CC_CR=0x0D, CC_BS=0x08, CC_FF=0x0C;
  - GLYPH_BASE=0x20 and GLYPH_LAST=0x5F;
  - the state encoding.
- Single module, no sub-module. The cursor and clear counter are plain counters; the clear counter is 2·CHR_SIZE_BITS wide.

## Test plan
- Reset, then send "AB" with palette_sel=2 -> writes addr 0 data 0xA1, then addr 1 data 0xA2, on consecutive cycles; cur_col=2.
- cursor_set (63,5), then send "X" -> write addr 5·64+63=383 data 0x38; cursor (0,6). With cursor (63,63), send "X" -> write addr 4095, cursor wraps to (0,0).
- Send "Q",0x0A,0x0D,0x08 from (3,0) -> one write at addr 3; cursor moves to (4,0), (0,1), (0,1), (0,1). BS saturates at col 0.
- Send 0x0C, palette_sel=1 -> busy high and chr_we high for exactly 4096 cycles, addresses 0..4095, data 0x40. in_valid held high during the clear is not accepted. Next byte is written at addr 0.
- Assert reset mid-clear at cell 1000 -> chr_we=0 immediately, busy=0, cursor (0,0). After release, "A" writes addr 0.
- Assert cursor_set and in_valid with 0x41 in the same cycle -> in_ready low, cursor loaded. The byte is accepted next cycle and written at the new cursor. Byte 0x7F -> consumed, no write, cursor unchanged.
